riscv_core_csa_accumulator: RTL and testbench

RISCV_CORE_CSA_ACCUMULATOR -- requirements
Module: riscv_core_csa_accumulator

---
 rtl/riscv_core_csa_accumulator_if.sv | 24 ++
 rtl/riscv_core_csa_accumulator.sv | 172 +++++++++++++++++
 tb/tb_riscv_core_csa_accumulator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_csa_accumulator_if.sv
// Operand/result handshake bundle for the carry-save accumulator.
// master = producer/consumer side, slave = the accumulator block.
interface riscv_core_csa_accumulator_if #(
    parameter int WIDTH = 64
);
    logic             i_acc_valid;
    logic             o_acc_ready;
    logic [WIDTH-1:0] i_acc_operand;
    logic             i_acc_last;
    logic             o_acc_valid;
    logic             i_acc_result_ready;
    logic [WIDTH-1:0] o_acc_result;
    logic             o_acc_ovf;

    modport master (
        output i_acc_valid, i_acc_operand, i_acc_last, i_acc_result_ready,
        input  o_acc_ready, o_acc_valid, o_acc_result, o_acc_ovf
    );

    modport slave (
        input  i_acc_valid, i_acc_operand, i_acc_last, i_acc_result_ready,
        output o_acc_ready, o_acc_valid, o_acc_result, o_acc_ovf
    );
endinterface

// File: rtl/riscv_core_csa_accumulator.sv
// Multi-operand unsigned accumulator: operands are folded in carry-save form at one per
// cycle, then the final carry-propagate add resolves CHUNK bits per cycle.
module riscv_core_csa_accumulator #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    riscv_core_csa_accumulator_if.slave   acc
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] c_r;
    logic             sticky_r;
    logic             chain_r;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] result_r;
    logic             ovf_r;

    logic             ready_s;
    logic             valid_s;
    logic             accept_s;
    logic             final_s;
    logic [31:0]      base_s;
    logic [WIDTH-1:0] csa_sum_s;
    logic [WIDTH-1:0] csa_maj_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic [WIDTH-1:0] resolved_s;

    function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign accept_s = acc.i_acc_valid & ready_s;
    assign final_s  = (state_r == ST_RESOLVE) && (k_r == K_LAST);

    // 3:2 compression of the incoming operand and one chunk of the resolving add
    always_comb begin
        base_s      = 32'(k_r) * 32'(CHUNK);
        csa_sum_s   = s_r ^ c_r ^ acc.i_acc_operand;
        csa_maj_s   = maj3(s_r, c_r, acc.i_acc_operand);
        chunk_sum_s = {1'b0, s_r[base_s +: CHUNK]} + {1'b0, c_r[base_s +: CHUNK]}
                    + {{CHUNK{1'b0}}, chain_r};
        // Resolved chunks overwrite S in place, so S holds the full result when done
        resolved_s  = s_r;
        resolved_s[base_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = ST_ACCUM;
        case (state_r)
            ST_ACCUM: begin
                if (accept_s && acc.i_acc_last) begin
                    state_next_s = ST_RESOLVE;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                if (k_r == K_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RESOLVE;
                end
            end
            ST_DONE: begin
                if (acc.i_acc_result_ready) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_ACCUM;
        endcase
    end

    // FSM output decode
    always_comb begin
        ready_s = 1'b0;
        valid_s = 1'b0;
        case (state_r)
            ST_ACCUM:   ready_s = 1'b1;
            ST_RESOLVE: ready_s = 1'b0;
            ST_DONE:    valid_s = 1'b1;
            default: begin
                ready_s = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // Accumulator, resolve sequencing and result capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_r      <= '0;
            c_r      <= '0;
            sticky_r <= 1'b0;
            chain_r  <= 1'b0;
            k_r      <= '0;
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s) begin
                        s_r      <= csa_sum_s;
                        c_r      <= csa_maj_s << 1;
                        // A majority bit in the MSB is a carry out of the word: lost forever
                        sticky_r <= sticky_r | csa_maj_s[WIDTH-1];
                        chain_r  <= 1'b0;
                        k_r      <= '0;
                    end
                end
                ST_RESOLVE: begin
                    s_r     <= resolved_s;
                    chain_r <= chunk_sum_s[CHUNK];
                    k_r     <= k_r + KW'(1);
                    if (final_s) begin
                        sticky_r <= sticky_r | chunk_sum_s[CHUNK];
                        result_r <= resolved_s;
                        ovf_r    <= sticky_r | chunk_sum_s[CHUNK];
                    end
                end
                ST_DONE: begin
                    if (acc.i_acc_result_ready) begin
                        s_r      <= '0;
                        c_r      <= '0;
                        sticky_r <= 1'b0;
                        chain_r  <= 1'b0;
                        k_r      <= '0;
                    end
                end
                default: begin
                    s_r      <= '0;
                    c_r      <= '0;
                    sticky_r <= 1'b0;
                    chain_r  <= 1'b0;
                    k_r      <= '0;
                end
            endcase
        end
    end

    assign acc.o_acc_ready  = ready_s;
    assign acc.o_acc_valid  = valid_s;
    assign acc.o_acc_result = result_r;
    assign acc.o_acc_ovf    = ovf_r;

endmodule

// File: tb/tb_riscv_core_csa_accumulator.sv
// Self-checking bench for riscv_core_csa_accumulator (WIDTH=64, CHUNK=16): directed
// vector table, backpressure/reset corner cases, and random sequences vs a 128-bit sum.
module tb_riscv_core_csa_accumulator;
    localparam int W = 64;

    typedef struct {
        int                 n;
        logic [2:0][W-1:0]  ops;
        logic [W-1:0]       exp_res;
        logic               exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passes = 0;
    int   fails = 0;

    riscv_core_csa_accumulator_if #(.WIDTH(W)) acc_if ();

    riscv_core_csa_accumulator #(.WIDTH(W), .CHUNK(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .acc     (acc_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand and return #1 after the edge that accepted it
    task automatic push(input logic [W-1:0] x, input logic l);
        int guard = 0;
        acc_if.i_acc_valid   = 1'b1;
        acc_if.i_acc_operand = x;
        acc_if.i_acc_last    = l;
        while (acc_if.o_acc_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            chk("ready_timeout", 64'(guard), 64'(0));
        end
        tick();
        acc_if.i_acc_valid   = 1'b0;
        acc_if.i_acc_operand = {$urandom, $urandom};
        acc_if.i_acc_last    = 1'($urandom_range(0, 1));
    endtask

    // Count edges from the last accept until o_acc_valid rises (bounded)
    task automatic wait_result(output int lat);
        lat = 0;
        while (acc_if.o_acc_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (lat >= 40) begin
            chk("result_timeout", 64'(lat), 64'(4));
        end
    endtask

    task automatic handshake();
        acc_if.i_acc_result_ready = 1'b1;
        tick();
        acc_if.i_acc_result_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, total);
        $fatal(1);
    end

    initial begin
        vec_t         vecs [6];
        int           lat;
        int           seen;
        int           len;
        logic [127:0] gold;
        logic [W-1:0] x;

        vecs[0] = '{1, {64'h0, 64'h0, 64'h1234}, 64'h0000_0000_0000_1234, 1'b0};
        vecs[1] = '{3, {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, 64'h0, 1'b1};
        vecs[2] = '{2, {64'h0, 64'h1, 64'h0000_0000_FFFF_FFFF}, 64'h0000_0001_0000_0000, 1'b0};
        vecs[3] = '{2, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[4] = '{3, {64'h5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000}, 64'h5, 1'b1};
        vecs[5] = '{1, {64'h0, 64'h0, 64'h0}, 64'h0, 1'b0};

        rst_n                     = 1'b0;
        acc_if.i_acc_valid        = 1'b0;
        acc_if.i_acc_operand      = '0;
        acc_if.i_acc_last         = 1'b0;
        acc_if.i_acc_result_ready = 1'b0;
        #12;
        chk("rst_ready",  64'(acc_if.o_acc_ready), 64'(1));
        chk("rst_valid",  64'(acc_if.o_acc_valid), 64'(0));
        chk("rst_result", acc_if.o_acc_result, 64'h0);
        chk("rst_ovf",    64'(acc_if.o_acc_ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed vector table, operands back-to-back
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                push(vecs[v].ops[j], (j == vecs[v].n - 1));
            end
            wait_result(lat);
            chk($sformatf("vec%0d_latency", v), 64'(lat), 64'(4));
            chk($sformatf("vec%0d_result", v), acc_if.o_acc_result, vecs[v].exp_res);
            chk($sformatf("vec%0d_ovf", v), 64'(acc_if.o_acc_ovf), 64'(vecs[v].exp_ovf));
            handshake();
            chk($sformatf("vec%0d_ready_after", v), 64'(acc_if.o_acc_ready), 64'(1));
        end

        // Result backpressure with an operand offered the whole time
        push(64'hAB, 1'b1);
        wait_result(lat);
        acc_if.i_acc_valid   = 1'b1;
        acc_if.i_acc_operand = 64'hDEAD;
        acc_if.i_acc_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_result", acc_if.o_acc_result, 64'hAB);
            chk("bp_ready",  64'(acc_if.o_acc_ready), 64'(0));
            chk("bp_valid",  64'(acc_if.o_acc_valid), 64'(1));
        end
        handshake();
        acc_if.i_acc_valid = 1'b0;
        chk("bp_hold_result", acc_if.o_acc_result, 64'hAB);
        chk("bp_valid_drop",  64'(acc_if.o_acc_valid), 64'(0));
        push(64'h5, 1'b0);
        push(64'h7, 1'b1);
        wait_result(lat);
        chk("bp_seq_result", acc_if.o_acc_result, 64'd12);
        chk("bp_seq_ovf",    64'(acc_if.o_acc_ovf), 64'(0));
        handshake();

        // Reset asserted at k = 2 of the resolve phase
        push(64'h1234_5678_9ABC_DEF0, 1'b0);
        push(64'hFFFF_0000_FFFF_0000, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",  64'(acc_if.o_acc_ready), 64'(1));
        chk("mid_rst_valid",  64'(acc_if.o_acc_valid), 64'(0));
        chk("mid_rst_result", acc_if.o_acc_result, 64'h0);
        chk("mid_rst_ovf",    64'(acc_if.o_acc_ovf), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (acc_if.o_acc_valid === 1'b1) seen++;
        end
        chk("post_rst_no_valid", 64'(seen), 64'(0));
        push(64'h3, 1'b1);
        wait_result(lat);
        chk("post_rst_result", acc_if.o_acc_result, 64'h3);
        chk("post_rst_ovf",    64'(acc_if.o_acc_ovf), 64'(0));
        handshake();

        // Random sequences against an exact 128-bit running sum
        for (int s = 0; s < 100; s++) begin
            len  = $urandom_range(1, 20);
            gold = '0;
            for (int j = 0; j < len; j++) begin
                case ($urandom_range(0, 3))
                    0:       x = 64'hFFFF_FFFF_FFFF_FFFF;
                    1:       x = 64'($urandom_range(0, 255));
                    default: x = {$urandom, $urandom};
                endcase
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    tick();
                end
                gold = gold + {64'h0, x};
                push(x, (j == len - 1));
            end
            wait_result(lat);
            for (int b = $urandom_range(0, 3); b > 0; b--) begin
                acc_if.i_acc_valid = 1'($urandom_range(0, 1));
                tick();
            end
            acc_if.i_acc_valid = 1'b0;
            chk($sformatf("rnd%0d_result", s), acc_if.o_acc_result, gold[63:0]);
            chk($sformatf("rnd%0d_ovf", s), 64'(acc_if.o_acc_ovf), 64'(gold[127:64] != 64'h0));
            handshake();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
